sipo_deser: RTL and testbench
=============================

SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, meaning word length in bits (legal range 2..32).
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port d  input  1  serial data bit, typically driven from the dff q output.
REQ-005 SHALL provide port d_en  input  1  bit strobe; d is sampled only on edges where d_en=1.
REQ-006 SHALL provide port out_ready  input  1  consumer accepts word when out_ready=1 and q_valid=1.
REQ-007 SHALL provide port q  output  WIDTH  assembled parallel word, first received bit in q[WIDTH-1].
REQ-008 SHALL provide port q_valid  output  1  q holds an unaccepted word.
REQ-009 SHALL provide port busy  output  1  a word is partially received (bit count nonzero).
REQ-010 SHALL provide port overrun  output  1  sticky flag; a completed word was dropped.

Function
REQ-011 SHALL shift MSB-first: on d_en=1, shift register becomes {sreg[WIDTH-2:0], d} and bit count increments.
REQ-012 SHALL hold shift register and bit count unchanged on edges with d_en=0.
REQ-013 SHALL, at the edge sampling the final data bit, load q with the completed word and set q_valid in that same edge (visible next cycle); bit count returns to 0.
REQ-014 SHALL keep q stable while q_valid=1 and no accept occurs.
REQ-015 SHALL clear q_valid at an edge where out_ready=1 and q_valid=1, unless a word completes on that same edge.
REQ-016 SHALL, on simultaneous accept and completion, load the new word into q and keep q_valid=1 without setting overrun.
REQ-017 SHALL, on completion while q_valid=1 and out_ready=0, discard the new word, keep q unchanged, and set overrun.
REQ-018 SHALL keep overrun set until reset; accepting words does not clear it.
REQ-019 SHALL continue receiving bits regardless of q_valid, so the block never back-pressures the serial input.
REQ-020 SHALL implement FSM states DATA (collecting data bits) and, only with the macro, PARITY (awaiting parity bit); DATA->PARITY after bit WIDTH-1, PARITY->DATA on the parity strobe.
REQ-021 SHALL drive busy=1 whenever bit count is nonzero or the FSM is in PARITY.

Reset
REQ-022 SHALL, with rst=1 at a rising edge, set q=0, q_valid=0, overrun=0, busy=0, shift register=0, bit count=0, FSM=DATA, and parity_err=0 when present.
REQ-023 SHALL give rst priority over d_en and out_ready on the same edge, discarding any partial word.

Configuration
REQ-024 SHALL, with macro SIPO_PARITY_EN defined, add output port parity_err (1 bit, sticky until reset) and expect one even-parity bit after the WIDTH data bits.
REQ-025 SHALL, with SIPO_PARITY_EN, present the word (rules REQ-013..017 applied at the parity edge) only if XOR of data and parity bits is 0; otherwise drop the word and set parity_err.
REQ-026 SHALL, without SIPO_PARITY_EN, omit parity_err and the PARITY state; a word completes after exactly WIDTH strobes.

Verification (WIDTH=8)
REQ-027 SHALL cover: reset then strobe bits 1,0,1,1,0,0,1,0 with out_ready=1 -> q=8'hB2, q_valid high for exactly one cycle, busy high for 7 cycles, overrun=0.
REQ-028 SHALL cover: d_en gapped (one strobe every 3 cycles) for 8'h5A -> q=8'h5A, and no state change on non-strobe edges.
REQ-029 SHALL cover: out_ready=0, send 8'h11 then 8'hEE -> q stays 8'h11, q_valid=1, overrun=1; then out_ready=1 -> q_valid clears and overrun stays 1.
REQ-030 SHALL cover: hold 8'h11 unaccepted, assert out_ready on the edge completing 8'h22 -> q=8'h22, q_valid=1, overrun=0.
REQ-031 SHALL cover: rst asserted after 4 bits, then full word 8'hC3 -> q=8'hC3, with the earlier partial bits not present in the word.
REQ-032 SHALL cover, with SIPO_PARITY_EN: 8'h03 plus parity 0 -> q=8'h03 valid; 8'h03 plus parity 1 -> no q_valid and parity_err=1.

Source files
------------

// File: rtl/sipo_deser_if.sv
// Serial-in / parallel-out deserializer bus: serial strobe in, word handshake out.
// parity_err is present only when SIPO_PARITY_EN is defined.
interface sipo_deser_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             d;
  logic             d_en;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             busy;
  logic             overrun;
`ifdef SIPO_PARITY_EN
  logic             parity_err;
`endif

  // Producer/consumer side of the block.
  modport master (
    output d, d_en, out_ready,
`ifdef SIPO_PARITY_EN
    input  parity_err,
`endif
    input  q, q_valid, busy, overrun
  );

  // Deserializer side.
  modport slave (
    input  d, d_en, out_ready,
`ifdef SIPO_PARITY_EN
    output parity_err,
`endif
    output q, q_valid, busy, overrun
  );
endinterface

// File: rtl/sipo_deser.sv
// MSB-first serial-to-parallel deserializer with a one-word output holding register.
// Define SIPO_PARITY_EN to expect an even-parity bit after each word and flag parity_err.
module sipo_deser #(
  parameter int unsigned WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  sipo_deser_if.slave bus
);
  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] new_word;
  logic             done;
  logic             good;

`ifdef SIPO_PARITY_EN
  typedef enum logic [0:0] {StData, StParity} state_e;
  state_e state_q, state_d;
  logic   perr_q, perr_d;
`endif

  assign shifted = {sreg_q[WIDTH-2:0], bus.d};

  always_comb begin
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    new_word  = shifted;
    done      = 1'b0;
    good      = 1'b1;
`ifdef SIPO_PARITY_EN
    state_d   = state_q;
    perr_d    = perr_q;
`endif

    if (bus.d_en) begin
`ifdef SIPO_PARITY_EN
      if (state_q == StParity) begin
        // Strobe carries the parity bit; data is already complete in sreg_q.
        state_d  = StData;
        done     = 1'b1;
        new_word = sreg_q;
        if (^{sreg_q, bus.d}) begin
          good   = 1'b0;
          perr_d = 1'b1;
        end
      end else begin
        sreg_d = shifted;
        if (cnt_q == LastBit) begin
          cnt_d   = '0;
          state_d = StParity;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`else
      sreg_d = shifted;
      if (cnt_q == LastBit) begin
        cnt_d = '0;
        done  = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
`endif
    end

    // A held word is released by accept; a completion on the accept edge replaces it.
    if (done && good) begin
      if (!valid_q || bus.out_ready) begin
        word_d  = new_word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q    <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SIPO_PARITY_EN
      state_q   <= StData;
      perr_q    <= 1'b0;
`endif
    end else begin
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
`ifdef SIPO_PARITY_EN
      state_q   <= state_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign bus.q       = word_q;
  assign bus.q_valid = valid_q;
  assign bus.overrun = overrun_q;
`ifdef SIPO_PARITY_EN
  assign bus.busy       = (cnt_q != '0) || (state_q == StParity);
  assign bus.parity_err = perr_q;
`else
  assign bus.busy       = (cnt_q != '0);
`endif
endmodule

// File: tb/tb_sipo_deser.sv
// Directed self-checking bench for sipo_deser (WIDTH=8); parity cases build with SIPO_PARITY_EN.
module tb_sipo_deser;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  sipo_deser_if #(.WIDTH(8)) bus ();
  sipo_deser #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

`ifdef SIPO_PARITY_EN
  localparam int ExtraBusy = 1;
`else
  localparam int ExtraBusy = 0;
`endif

  // All driving and sampling happens at falling edges; the DUT updates at rising edges.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.d = 1'b1; bus.d_en = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.d = 1'b0; bus.d_en = 1'b0; bus.out_ready = 1'b0;
  endtask

  // Sends w MSB-first with 'gap' idle cycles between strobes (none after the last one),
  // followed by the even-parity bit (optionally inverted) in parity builds.
  task automatic send_word(input logic [7:0] w, input int gap, input bit ready_last,
                           input bit flip_par, output int busy_cycles);
    int nbits;
    logic [8:0] bits;
    busy_cycles = 0;
    bits = {w, (^w) ^ flip_par};
    nbits = 8 + ExtraBusy;
    for (int i = 0; i < nbits; i++) begin
      bus.d = bits[8-i];
      bus.d_en = 1'b1;
      if (ready_last && i == nbits - 1) bus.out_ready = 1'b1;
      @(negedge clk);
      bus.d_en = 1'b0;
      if (bus.busy) busy_cycles++;
      if (i != nbits - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          if (bus.busy) busy_cycles++;
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.d = 1'b0; bus.d_en = 1'b0; bus.out_ready = 1'b0; rst = 1'b0;
    do_reset();
    n_checks++; if (bus.q !== 8'h00) begin n_fail++; $display("FAIL reset_q got %h want 00", bus.q); end
    n_checks++; if (bus.q_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.q_valid); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
  endtask

  task automatic test_basic();
    int bc;
    do_reset();
    bus.out_ready = 1'b1;
    send_word(8'hB2, 0, 1'b0, 1'b0, bc);
    n_checks++; if (bus.q !== 8'hB2) begin n_fail++; $display("FAIL basic_q got %h want b2", bus.q); end
    n_checks++; if (bus.q_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", bus.q_valid); end
    n_checks++; if (bc !== 7 + ExtraBusy) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want %0d", bc, 7 + ExtraBusy); end
    @(negedge clk);
    n_checks++; if (bus.q_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_pulse got %b want 0", bus.q_valid); end
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL basic_overrun got %b want 0", bus.overrun); end
  endtask

  task automatic test_gapped();
    int bc;
    do_reset();
    bus.out_ready = 1'b1;
    send_word(8'h5A, 2, 1'b0, 1'b0, bc);
    n_checks++; if (bus.q !== 8'h5A) begin n_fail++; $display("FAIL gapped_q got %h want 5a", bus.q); end
    n_checks++; if (bus.q_valid !== 1'b1) begin n_fail++; $display("FAIL gapped_valid got %b want 1", bus.q_valid); end
    n_checks++; if (bc !== 3 * (7 + ExtraBusy)) begin n_fail++; $display("FAIL gapped_busy_cycles got %0d want %0d", bc, 3 * (7 + ExtraBusy)); end
    @(negedge clk);
  endtask

  task automatic test_overrun();
    int bc;
    do_reset();
    send_word(8'h11, 0, 1'b0, 1'b0, bc);
    n_checks++; if (bus.q !== 8'h11) begin n_fail++; $display("FAIL ovr_first_q got %h want 11", bus.q); end
    send_word(8'hEE, 0, 1'b0, 1'b0, bc);
    n_checks++; if (bus.q !== 8'h11) begin n_fail++; $display("FAIL ovr_held_q got %h want 11", bus.q); end
    n_checks++; if (bus.q_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid got %b want 1", bus.q_valid); end
    n_checks++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got %b want 1", bus.overrun); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.q_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_accept_valid got %b want 0", bus.q_valid); end
    n_checks++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got %b want 1", bus.overrun); end
  endtask

  task automatic test_back_to_back();
    int bc;
    do_reset();
    send_word(8'h11, 0, 1'b0, 1'b0, bc);
    send_word(8'h22, 0, 1'b1, 1'b0, bc);
    n_checks++; if (bus.q !== 8'h22) begin n_fail++; $display("FAIL b2b_q got %h want 22", bus.q); end
    n_checks++; if (bus.q_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %b want 1", bus.q_valid); end
    n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun got %b want 0", bus.overrun); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int bc;
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.d = 1'b1; bus.d_en = 1'b1;
      @(negedge clk);
    end
    // Reset with a strobe asserted on the same edge; the strobe must be ignored.
    rst = 1'b1; bus.d = 1'b1; bus.d_en = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.d_en = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
    send_word(8'hC3, 0, 1'b0, 1'b0, bc);
    n_checks++; if (bus.q !== 8'hC3) begin n_fail++; $display("FAIL rstmid_q got %h want c3", bus.q); end
    n_checks++; if (bus.q_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_valid got %b want 1", bus.q_valid); end
    @(negedge clk);
  endtask

`ifdef SIPO_PARITY_EN
  task automatic test_parity();
    int bc;
    do_reset();
    bus.out_ready = 1'b1;
    send_word(8'h03, 0, 1'b0, 1'b0, bc);
    n_checks++; if (bus.q !== 8'h03) begin n_fail++; $display("FAIL par_ok_q got %h want 03", bus.q); end
    n_checks++; if (bus.q_valid !== 1'b1) begin n_fail++; $display("FAIL par_ok_valid got %b want 1", bus.q_valid); end
    n_checks++; if (bus.parity_err !== 1'b0) begin n_fail++; $display("FAIL par_ok_err got %b want 0", bus.parity_err); end
    @(negedge clk);
    send_word(8'h03, 0, 1'b0, 1'b1, bc);
    n_checks++; if (bus.q_valid !== 1'b0) begin n_fail++; $display("FAIL par_bad_valid got %b want 0", bus.q_valid); end
    n_checks++; if (bus.parity_err !== 1'b1) begin n_fail++; $display("FAIL par_bad_err got %b want 1", bus.parity_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
`ifdef SIPO_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
